// File: rtl/pulse_gen_fsm_if.sv
// rtl/pulse_gen_fsm_if.sv - trigger in, pulse level and drop status out.
interface pulse_gen_fsm_if;
    logic       tick;
    logic       level;
    logic       busy;
    logic       drop;
    logic [7:0] drop_cnt;

    modport master (output tick, input level, busy, drop, drop_cnt);
    modport slave  (input tick, output level, busy, drop, drop_cnt);
endinterface

// File: rtl/pulse_gen_fsm.sv
// rtl/pulse_gen_fsm.sv - single-shot pulse generator: delay, level width, hold-off gap.
// Moore FSM sharing one down-counter across the timed states.
module pulse_gen_fsm #(
    parameter int unsigned DLY_CYC  = 2,
    parameter int unsigned HIGH_CYC = 4,
    parameter int unsigned GAP_CYC  = 1,
    parameter bit          RETRIG   = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    pulse_gen_fsm_if.slave pif
);

    if (HIGH_CYC < 1 || HIGH_CYC > 255) begin : g_bad_high
        $error("pulse_gen_fsm: HIGH_CYC must be 1..255");
    end
    if (DLY_CYC > 255 || GAP_CYC > 255) begin : g_bad_range
        $error("pulse_gen_fsm: DLY_CYC and GAP_CYC must be 0..255");
    end

    localparam logic [7:0] DLY_LD  = (DLY_CYC == 0) ? 8'd0 : 8'(DLY_CYC - 1);
    localparam logic [7:0] HIGH_LD = 8'(HIGH_CYC - 1);
    localparam logic [7:0] GAP_LD  = (GAP_CYC == 0) ? 8'd0 : 8'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DLY  = 2'd1,
        S_HIGH = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       drop_q, drop_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       reject;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            drop_q     <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Acceptance depends only on the registered state, never on the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 8'd1;
        reject  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (pif.tick) begin
                    if (DLY_CYC == 0) begin
                        state_d = S_HIGH;
                        cnt_d   = HIGH_LD;
                    end else begin
                        state_d = S_DLY;
                        cnt_d   = DLY_LD;
                    end
                end
            end
            S_DLY: begin
                reject = pif.tick;
                if (cnt_q == 8'd0) begin
                    state_d = S_HIGH;
                    cnt_d   = HIGH_LD;
                end
            end
            S_HIGH: begin
                if (RETRIG && pif.tick) begin
                    cnt_d = HIGH_LD;
                end else begin
                    reject = pif.tick;
                    if (cnt_q == 8'd0) begin
                        if (GAP_CYC == 0) begin
                            state_d = S_IDLE;
                            cnt_d   = 8'd0;
                        end else begin
                            state_d = S_GAP;
                            cnt_d   = GAP_LD;
                        end
                    end
                end
            end
            S_GAP: begin
                reject = pif.tick;
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        drop_d     = reject;
        drop_cnt_d = drop_cnt_q;
        if (reject && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_comb begin
        pif.level    = 1'b0;
        pif.busy     = 1'b0;
        pif.drop     = drop_q;
        pif.drop_cnt = drop_cnt_q;
        case (state_q)
            S_DLY:   pif.busy = 1'b1;
            S_HIGH:  begin
                pif.level = 1'b1;
                pif.busy  = 1'b1;
            end
            S_GAP:   pif.busy = 1'b1;
            default: begin
                pif.level = 1'b0;
                pif.busy  = 1'b0;
            end
        endcase
    end

endmodule
